// File: rtl/axi4_sram_responder.sv
// AXI4 slave SRAM model: independent read/write FSMs, ID echo, FIXED/INCR/WRAP bursts, programmable latency.
// Optional macro AXI4_SRAM_DECERR_EN: addresses outside the mapped window answer DECERR instead of aliasing.
module axi4_sram_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0f00_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_arready,
  input  logic        in_arvalid,
  input  logic [3:0]  in_arid,
  input  logic [31:0] in_araddr,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  input  logic        in_rready,
  output logic        in_rvalid,
  output logic [3:0]  in_rid,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rlast,
  output logic        in_awready,
  input  logic        in_awvalid,
  input  logic [3:0]  in_awid,
  input  logic [31:0] in_awaddr,
  input  logic [7:0]  in_awlen,
  input  logic [2:0]  in_awsize,
  input  logic [1:0]  in_awburst,
  output logic        in_wready,
  input  logic        in_wvalid,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_wlast,
  input  logic        in_bready,
  output logic        in_bvalid,
  output logic [3:0]  in_bid,
  output logic [1:0]  in_bresp
);

  localparam int unsigned   AW     = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned   CW     = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [1:0]    RESP_DECERR = 2'b11;
`ifdef AXI4_SRAM_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_t;

  function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] inc;
    logic [31:0] wmask;
    inc   = addr + (32'd1 << size);
    wmask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    f_next_addr = inc;
    if (burst == 2'b00)
      f_next_addr = addr;
    else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      f_next_addr = (addr & ~wmask) | (inc & wmask);
  endfunction

  function automatic logic [AW-1:0] f_idx(input logic [31:0] addr);
    f_idx = AW'((addr - BASE_ADDR) >> 2);
  endfunction

  // Out-of-window beats outrank oversize beats.
  function automatic logic [1:0] f_beat_resp(input logic [31:0] addr, input logic [2:0] size);
    logic [32:0] off;
    off = {1'b0, addr - BASE_ADDR};
    if (DECERR_EN && off >= (33'(DEPTH) << 2)) f_beat_resp = RESP_DECERR;
    else if (size > 3'd2)                      f_beat_resp = RESP_SLVERR;
    else                                       f_beat_resp = RESP_OKAY;
  endfunction

  logic [31:0] r_mem [DEPTH];

  rstate_t       r_rstate;
  logic          r_arready, r_rvalid, r_rlast;
  logic [3:0]    r_rid;
  logic [31:0]   r_rdata, r_raddr;
  logic [1:0]    r_rresp, r_rburst;
  logic [7:0]    r_rlen, r_rbeat;
  logic [2:0]    r_rsize;
  logic [CW-1:0] r_rcnt;

  wstate_t       r_wstate;
  logic          r_awready, r_wready, r_bvalid, r_wpast, r_wslv, r_wdec;
  logic [3:0]    r_bid;
  logic [1:0]    r_bresp, r_wburst;
  logic [31:0]   r_waddr;
  logic [7:0]    r_wlen, r_wbeat;
  logic [2:0]    r_wsize;
  logic [CW-1:0] r_wcnt;

  logic [31:0] w_rd_next_addr, w_rd_addr, w_rd_data;
  logic [1:0]  w_rd_resp;
  logic [31:0] w_wr_next_addr;
  logic [1:0]  w_wr_resp;
  logic        w_wfire, w_wcommit;

  always_comb begin
    w_rd_next_addr = f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
    w_rd_addr      = (r_rstate == R_DATA) ? w_rd_next_addr : r_raddr;
    w_rd_resp      = f_beat_resp(w_rd_addr, r_rsize);
    w_rd_data      = (w_rd_resp == RESP_OKAY) ? r_mem[f_idx(w_rd_addr)] : '0;
    w_wr_next_addr = f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
    w_wr_resp      = f_beat_resp(r_waddr, r_wsize);
    w_wfire        = (r_wstate == W_DATA) && in_wvalid;
    w_wcommit      = w_wfire && !r_wpast && (w_wr_resp == RESP_OKAY) && !reset;
  end

  // Reads sample r_mem before this edge's write lands, so same-word collisions return old data.
  always_ff @(posedge clock) begin
    if (w_wcommit)
      for (int unsigned b = 0; b < 4; b++)
        if (in_wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= in_wdata[8*b +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rbeat   <= '0;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (in_arvalid) begin
          r_arready <= 1'b0;
          r_rid     <= in_arid;
          r_raddr   <= in_araddr;
          r_rlen    <= in_arlen;
          r_rsize   <= in_arsize;
          r_rburst  <= in_arburst;
          r_rbeat   <= '0;
          r_rcnt    <= '0;
          r_rstate  <= R_WAIT;
        end
        R_WAIT: if (r_rcnt == LAT_M1) begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd_data;
          r_rresp  <= w_rd_resp;
          r_rlast  <= (r_rlen == 8'd0);
          r_rstate <= R_DATA;
        end else begin
          r_rcnt <= r_rcnt + 1'b1;
        end
        R_DATA: if (in_rready) begin
          if (r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_raddr <= w_rd_next_addr;
            r_rbeat <= r_rbeat + 8'd1;
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_wbeat   <= '0;
      r_wcnt    <= '0;
      r_wpast   <= 1'b0;
      r_wslv    <= 1'b0;
      r_wdec    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (in_awvalid) begin
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_bid     <= in_awid;
          r_waddr   <= in_awaddr;
          r_wlen    <= in_awlen;
          r_wsize   <= in_awsize;
          r_wburst  <= in_awburst;
          r_wbeat   <= '0;
          r_wpast   <= 1'b0;
          r_wslv    <= 1'b0;
          r_wdec    <= 1'b0;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (in_wvalid) begin
          // Once beat len has gone by without wlast, later beats are only drained.
          if (!r_wpast) begin
            if (w_wr_resp == RESP_DECERR) r_wdec <= 1'b1;
            if (w_wr_resp == RESP_SLVERR) r_wslv <= 1'b1;
            if (in_wlast && r_wbeat != r_wlen) r_wslv <= 1'b1;
            if (!in_wlast && r_wbeat == r_wlen) begin
              r_wslv  <= 1'b1;
              r_wpast <= 1'b1;
            end
            r_waddr <= w_wr_next_addr;
            r_wbeat <= r_wbeat + 8'd1;
          end
          if (in_wlast) begin
            r_wready <= 1'b0;
            r_wcnt   <= '0;
            r_wstate <= W_WAIT;
          end
        end
        W_WAIT: if (r_wcnt == LAT_M1) begin
          r_bvalid <= 1'b1;
          r_bresp  <= r_wdec ? RESP_DECERR : (r_wslv ? RESP_SLVERR : RESP_OKAY);
          r_wstate <= W_RESP;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
        W_RESP: if (in_bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign in_arready = r_arready;
  assign in_rvalid  = r_rvalid;
  assign in_rid     = r_rid;
  assign in_rdata   = r_rdata;
  assign in_rresp   = r_rresp;
  assign in_rlast   = r_rlast;
  assign in_awready = r_awready;
  assign in_wready  = r_wready;
  assign in_bvalid  = r_bvalid;
  assign in_bid     = r_bid;
  assign in_bresp   = r_bresp;

endmodule
